// File: rtl/k12a_io_hub.sv
// K12A memory-mapped I/O hub: synchronised inputs with sticky rising-edge flags,
// read-back output registers and a self-timed HD44780-style LCD strobe sequencer.
module k12a_io_hub #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_IN        = 2,
  parameter int unsigned NUM_OUT       = 4,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned LCD_EN_CYCLES = 4
) (
  input  logic                          cpu_clock,
  input  logic                          reset_n,
  input  logic                          io_load,
  input  logic                          io_store,
  input  logic [ADDR_WIDTH-1:0]         io_addr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  input  logic [NUM_IN*DATA_WIDTH-1:0]  in_pins,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_pins,
  output logic                          lcd_rs,
  output logic                          lcd_rw,
  output logic                          lcd_en,
  output logic [DATA_WIDTH-1:0]         lcd_data
);

  localparam int unsigned NumRegs = 2 * NUM_IN + NUM_OUT + 2;
  localparam logic [ADDR_WIDTH-1:0] AddrLcdData = ADDR_WIDTH'(2 * NUM_IN + NUM_OUT);
  localparam logic [ADDR_WIDTH-1:0] AddrLcdCtrl = ADDR_WIDTH'(2 * NUM_IN + NUM_OUT + 1);
  localparam int unsigned CntW = (LCD_EN_CYCLES > 1) ? $clog2(LCD_EN_CYCLES) : 1;

  // Reject configurations whose register map cannot be addressed.
  if (NumRegs > (2 ** ADDR_WIDTH)) begin : g_bad_addr
    $error("k12a_io_hub: register map does not fit in io_addr");
  end
  if (LCD_EN_CYCLES < 1) begin : g_bad_en
    $error("k12a_io_hub: LCD_EN_CYCLES must be at least 1");
  end
  if (DATA_WIDTH < 8) begin : g_bad_width
    $error("k12a_io_hub: LCD status layout needs DATA_WIDTH >= 8");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} lcd_state_e;

  logic [NUM_IN*DATA_WIDTH-1:0]  s1_q, s2_q, s3_q;
  logic [NUM_IN*DATA_WIDTH-1:0]  edge_q, edge_d;
  logic [NUM_OUT*DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0]         lcd_data_q;
  logic                          rs_q, rw_q, en_q, overrun_q;
  logic [CntW-1:0]               cnt_q;
  lcd_state_e                    state_q;
  logic                          busy, wr_lcd_data, wr_lcd_ctrl;

  assign busy        = (state_q != StIdle);
  assign wr_lcd_data = io_store && (io_addr == AddrLcdData);
  assign wr_lcd_ctrl = io_store && (io_addr == AddrLcdCtrl);

  assign out_pins = out_q;
  assign lcd_data = lcd_data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = rw_q;
  assign lcd_en   = en_q;

  // Edge flags: clear-on-read first, then new rising edges OR in so none are lost.
  always_comb begin
    edge_d = edge_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (io_load && (io_addr == ADDR_WIDTH'(NUM_IN + i))) begin
        edge_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
    edge_d = edge_d | (s2_q & ~s3_q);
  end

  // Output register write decode.
  always_comb begin
    out_d = out_q;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (io_store && (io_addr == ADDR_WIDTH'(2 * NUM_IN + j))) begin
        out_d[j*DATA_WIDTH +: DATA_WIDTH] = wdata;
      end
    end
  end

  // Read mux; shows pre-write state when load and store coincide.
  always_comb begin
    rdata = '0;
    if (io_load) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (io_addr == ADDR_WIDTH'(i)) rdata = s2_q[i*DATA_WIDTH +: DATA_WIDTH];
        if (io_addr == ADDR_WIDTH'(NUM_IN + i)) rdata = edge_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int j = 0; j < NUM_OUT; j++) begin
        if (io_addr == ADDR_WIDTH'(2 * NUM_IN + j)) rdata = out_q[j*DATA_WIDTH +: DATA_WIDTH];
      end
      if (io_addr == AddrLcdCtrl) begin
        rdata[7] = busy;
        rdata[6] = overrun_q;
        rdata[1] = rw_q;
        rdata[0] = rs_q;
      end
    end
  end

  // Input synchroniser, edge-detect delay stage, edge flags and output registers.
  always_ff @(posedge cpu_clock) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      edge_q <= '0;
      out_q  <= '0;
    end else begin
      s1_q   <= in_pins;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= edge_d;
      out_q  <= out_d;
    end
  end

  // LCD sequencer: SETUP -> PULSE (en high) -> HOLD, with registered controls.
  always_ff @(posedge cpu_clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      lcd_data_q <= '0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (wr_lcd_ctrl) begin
        rs_q <= wdata[0];
        rw_q <= wdata[1];
      end
      // A dropped data write beats a simultaneous clear.
      if (wr_lcd_data && busy) begin
        overrun_q <= 1'b1;
      end else if (wr_lcd_ctrl) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (wr_lcd_data) begin
            lcd_data_q <= wdata;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          state_q <= StPulse;
          en_q    <= 1'b1;
          cnt_q   <= CntW'(LCD_EN_CYCLES - 1);
        end
        StPulse: begin
          if (cnt_q == '0) begin
            state_q <= StHold;
            en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
